piso_10_tx: RTL and testbench

//  Parallel-in serial-out transmitter: accepts WIDTH-bit words via valid/ready handshake and

---
 rtl/piso_10_tx_if.sv | 23 ++
 rtl/piso_10_tx.sv | 71 +++++++
 tb/tb_piso_10_tx.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/piso_10_tx_if.sv
// Word-in / bit-out bundle between a word producer and the serial transmitter.
// The master side drives words and line enable; the slave side is the transmitter.
interface piso_10_tx_if #(
    parameter int WIDTH = 10
);
    logic             ENABLE_IN;
    logic [WIDTH-1:0] DATA_IN;
    logic             DATA_VALID_IN;
    logic             DATA_READY_OUT;
    logic             SERIAL_OUT;
    logic             FRAME_START_OUT;
    logic             UNDERRUN_OUT;

    modport master (
        output ENABLE_IN, DATA_IN, DATA_VALID_IN,
        input  DATA_READY_OUT, SERIAL_OUT, FRAME_START_OUT, UNDERRUN_OUT
    );

    modport slave (
        input  ENABLE_IN, DATA_IN, DATA_VALID_IN,
        output DATA_READY_OUT, SERIAL_OUT, FRAME_START_OUT, UNDERRUN_OUT
    );
endinterface

// File: rtl/piso_10_tx.sv
// Parallel-in serial-out line transmitter: LSB-first frames of WIDTH bits, one-word
// holding buffer behind a valid/ready handshake, IDLE_WORD sent when nothing is queued.
module piso_10_tx #(
    parameter int               WIDTH     = 10,
    parameter logic [WIDTH-1:0] IDLE_WORD = '0
) (
    input logic          CLK_IN,
    input logic          RESET_N_IN,
    piso_10_tx_if.slave  bus
);
    localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] hold_reg;
    logic             hold_full;
    logic [CW-1:0]    bit_ctr;
    logic             underrun;

    logic accept;
    logic boundary;

    // Accept only into an empty buffer; boundary is the last enabled bit of a frame.
    assign accept   = bus.DATA_VALID_IN && !hold_full;
    assign boundary = bus.ENABLE_IN && (bit_ctr == LAST);

    always_ff @(posedge CLK_IN or negedge RESET_N_IN) begin
        if (!RESET_N_IN) begin
            shift_reg <= IDLE_WORD;
            bit_ctr   <= '0;
            underrun  <= 1'b0;
        end else begin
            underrun <= 1'b0;
            if (bus.ENABLE_IN) begin
                if (bit_ctr == LAST) begin
                    bit_ctr <= '0;
                    if (hold_full) begin
                        shift_reg <= hold_reg;
                    end else begin
                        shift_reg <= IDLE_WORD;
                        underrun  <= 1'b1;
                    end
                end else begin
                    shift_reg <= shift_reg >> 1;
                    bit_ctr   <= bit_ctr + CW'(1);
                end
            end
        end
    end

    // Draining and accepting are exclusive: accept needs an empty buffer, drain a full one,
    // so a word offered in the draining cycle waits until READY rises.
    always_ff @(posedge CLK_IN or negedge RESET_N_IN) begin
        if (!RESET_N_IN) begin
            hold_reg  <= '0;
            hold_full <= 1'b0;
        end else begin
            if (accept) begin
                hold_reg  <= bus.DATA_IN;
                hold_full <= 1'b1;
            end else if (boundary && hold_full) begin
                hold_full <= 1'b0;
            end
        end
    end

    assign bus.SERIAL_OUT      = shift_reg[0];
    assign bus.FRAME_START_OUT = (bit_ctr == '0);
    assign bus.DATA_READY_OUT  = !hold_full;
    assign bus.UNDERRUN_OUT    = underrun;
endmodule

// File: tb/tb_piso_10_tx.sv
// Bench for piso_10_tx: directed scenarios plus random traffic, all checked against a
// frame-level model (current word, bit position, queued words).
module tb_piso_10_tx;
    localparam int         W    = 10;
    localparam logic [9:0] IDLE = 10'h2C3;

    logic CLK_IN;
    logic RESET_N_IN;

    piso_10_tx_if #(.WIDTH(W)) bus ();

    piso_10_tx #(.WIDTH(W), .IDLE_WORD(IDLE)) dut (
        .CLK_IN    (CLK_IN),
        .RESET_N_IN(RESET_N_IN),
        .bus       (bus)
    );

    initial begin
        CLK_IN = 1'b0;
        forever #5 CLK_IN = ~CLK_IN;
    end

    int checks = 0;
    int errors = 0;

    // Model: word on the line, which of its bits is out, words waiting, last underrun.
    logic [9:0] m_word;
    int         m_pos;
    logic [9:0] m_q[$];
    logic       m_und;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_word = IDLE;
        m_pos  = 0;
        m_q.delete();
        m_und  = 1'b0;
    endtask

    task automatic check_outputs();
        chk("serial", 32'(bus.SERIAL_OUT), 32'((m_word >> m_pos) & 10'h1));
        chk("frame_start", 32'(bus.FRAME_START_OUT), 32'(m_pos == 0));
        chk("ready", 32'(bus.DATA_READY_OUT), 32'(m_q.size() == 0));
        chk("underrun", 32'(bus.UNDERRUN_OUT), 32'(m_und));
    endtask

    // Called at a falling edge: check, drive, advance the model across the next rising edge.
    task automatic step(input logic en, input logic vld, input logic [9:0] d);
        bit acc;
        check_outputs();
        bus.ENABLE_IN     = en;
        bus.DATA_VALID_IN = vld;
        bus.DATA_IN       = d;
        acc   = vld && (m_q.size() == 0);
        m_und = 1'b0;
        if (en) begin
            if (m_pos == W - 1) begin
                m_pos = 0;
                if (m_q.size() > 0) begin
                    m_word = m_q.pop_front();
                end else begin
                    m_word = IDLE;
                    m_und  = 1'b1;
                end
            end else begin
                m_pos++;
            end
        end
        if (acc) m_q.push_back(d);
        @(negedge CLK_IN);
    endtask

    task automatic send(input logic [9:0] d);
        bit acc;
        int n = 0;
        do begin
            acc = (m_q.size() == 0);
            step(1'b1, 1'b1, d);
            n++;
        end while (!acc && n < 40);
        if (!acc) chk("send_timeout", 32'(n), 32'(0));
    endtask

    task automatic advance_to(input int p);
        int n = 0;
        while (m_pos != p && n < 40) begin
            step(1'b1, 1'b0, 10'h0);
            n++;
        end
        if (m_pos != p) chk("advance_timeout", 32'(m_pos), 32'(p));
    endtask

    task automatic capture_frame(input string tag, input logic [9:0] exp);
        logic [9:0] bits;
        chk({tag, "_fstart"}, 32'(bus.FRAME_START_OUT), 32'(1));
        chk({tag, "_und"}, 32'(bus.UNDERRUN_OUT), 32'(0));
        for (int k = 0; k < W; k++) begin
            bits[k] = bus.SERIAL_OUT;
            step(1'b1, 1'b0, 10'h0);
        end
        chk(tag, 32'(bits), 32'(exp));
    endtask

    task automatic do_reset();
        RESET_N_IN = 1'b0;
        #2;
        model_reset();
        check_outputs();
        @(negedge CLK_IN);
        check_outputs();
        RESET_N_IN = 1'b1;
    endtask

    initial begin
        int ucnt;
        int fcnt;
        bus.ENABLE_IN     = 1'b0;
        bus.DATA_VALID_IN = 1'b0;
        bus.DATA_IN       = '0;
        RESET_N_IN        = 1'b0;
        model_reset();
        @(negedge CLK_IN);
        #2;
        check_outputs();
        @(negedge CLK_IN);
        RESET_N_IN = 1'b1;

        // Idle line after reset: three boundaries in 30 cycles.
        ucnt = 0;
        fcnt = 0;
        for (int i = 0; i < 30; i++) begin
            step(1'b1, 1'b0, 10'h0);
            ucnt += int'(bus.UNDERRUN_OUT);
            fcnt += int'(bus.FRAME_START_OUT);
        end
        chk("idle_underruns", 32'(ucnt), 32'(3));
        chk("idle_frame_starts", 32'(fcnt), 32'(3));

        // One word offered mid-frame goes out LSB first on the next frame.
        advance_to(3);
        send(10'h2B5);
        advance_to(0);
        capture_frame("w2b5", 10'h2B5);

        // Producer holding VALID: three back-to-back frames.
        send(10'h3FF);
        send(10'h001);
        send(10'h155);
        advance_to(0);
        capture_frame("w155", 10'h155);

        // Accept on the boundary edge with an empty buffer: idle frame first.
        advance_to(W - 1);
        step(1'b1, 1'b1, 10'h0F0);
        chk("edge_accept_und", 32'(bus.UNDERRUN_OUT), 32'(1));
        for (int k = 0; k < W; k++) step(1'b1, 1'b0, 10'h0);
        capture_frame("w0f0", 10'h0F0);

        // Enable dropped for 5 cycles at bit 4: frame spans 15 cycles.
        send(10'h2B5);
        advance_to(0);
        for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 10'h0);
        for (int k = 0; k < 5; k++) begin
            chk("frozen_bit4", 32'(bus.SERIAL_OUT), 32'(1));
            step(1'b0, 1'b0, 10'h0);
        end
        for (int k = 0; k < 6; k++) step(1'b1, 1'b0, 10'h0);
        chk("stretched_frame_end", 32'(bus.FRAME_START_OUT), 32'(1));

        // Reset mid-frame with a word held: the word is lost.
        send(10'h1A7);
        send(10'h0C3);
        step(1'b1, 1'b0, 10'h0);
        do_reset();
        for (int i = 0; i < 25; i++) step(1'b1, 1'b0, 10'h0);

        // Random traffic with occasional reset.
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
            end else begin
                step(($urandom_range(0, 9) != 0), ($urandom_range(0, 1) == 1),
                     10'($urandom));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
